// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock with a registered inter-chunk carry.
// Latency NCHUNK cycles from the start edge to done; start is ignored while busy.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, work, work_nxt;
  logic             carry, a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   csum;
  logic             last, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CW'(NCHUNK - 1));
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right one chunk per cycle; the result shifts in from the top,
  // so after NCHUNK steps chunk 0 has landed in the least significant position.
  always_comb begin
    csum     = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + (CHUNK+1)'(carry);
    work_nxt = WIDTH'({csum[CHUNK-1:0], work} >> CHUNK);
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub;
        a_msb <= a[WIDTH-1];
        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        cnt   <= '0;
      end else if (state == RUN) begin
        opa   <= opa >> CHUNK;
        opb   <= opb >> CHUNK;
        work  <= work_nxt;
        carry <= csum[CHUNK];
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= work_nxt;
          cout <= csum[CHUNK];
          ovf  <= (a_msb == b_msb) && (work_nxt[WIDTH-1] != a_msb);
          done <= 1'b1;
          cnt  <= '0;
        end
      end
    end
  end

endmodule
